// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one SPI engine,
// one transfer at a time, with a per-transfer WAIT timeout.
`ifndef SPI_DATA_WIDTH
`define SPI_DATA_WIDTH 8
`endif

module spi_req_arbiter #(
    parameter int DATA_WIDTH = `SPI_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          eng_start,
    output logic [DATA_WIDTH-1:0]         eng_tx_data,
    input  logic                          eng_busy,
    input  logic                          eng_done,
    input  logic [DATA_WIDTH-1:0]         eng_rx_data
);

    localparam int         IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // WAIT exits on the edge where the counter would reach TIMEOUT.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state_reg;
    logic [IDX_W-1:0]        ptr_reg;
    logic [IDX_W-1:0]        gnt_idx_reg;
    logic [7:0]              cnt_reg;
    logic [IDX_W-1:0]        win_idx;
    logic                    win_valid;
    logic [DATA_WIDTH-1:0]   req_words [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
            assign req_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDX_W'(sum);
    endfunction

    // Scan offsets from the far end down so the nearest requester at or
    // above ptr is the last (winning) assignment.
    always_comb begin
        win_idx   = '0;
        win_valid = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_add(ptr_reg, k)]) win_idx = wrap_add(ptr_reg, k);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            grant       <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            eng_start   <= 1'b0;
            eng_tx_data <= '0;
            ptr_reg     <= '0;
            gnt_idx_reg <= '0;
            cnt_reg     <= '0;
        end else begin
            eng_start <= 1'b0;
            rsp_valid <= '0;
            case (state_reg)
                IDLE: begin
                    if (win_valid && !eng_busy) begin
                        grant       <= NUM_REQ'(1) << win_idx;
                        gnt_idx_reg <= win_idx;
                        eng_tx_data <= req_words[win_idx];
                        state_reg   <= ISSUE;
                    end
                end
                ISSUE: begin
                    eng_start <= 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    cnt_reg <= cnt_reg + 8'd1;
                    // A done arriving on the timeout edge still counts as success.
                    if (eng_done) begin
                        rsp_data  <= eng_rx_data;
                        rsp_err   <= 1'b0;
                        rsp_valid <= grant;
                        state_reg <= RESP;
                    end else if (cnt_reg == CNT_LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= grant;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    ptr_reg   <= wrap_add(gnt_idx_reg, 1);
                    grant     <= '0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
